flit_sink: RTL

- Terminal consumer for flits produced by a node source and delivered through the serial rx deserializer.
- Accepts single-cycle `req`/`data` flit pulses into a small FIFO and drains them at a modelled consumption rate.
- Exerts backpressure on the rx stage through `busy`.
- Checks each flit's destination field against its own node id and keeps received, misrouted and overflow statistics for testbench scoreboarding.

---
 rtl/flit_sink_pkg.sv | 22 ++
 rtl/sink_fifo.sv | 57 +++++
 rtl/flit_sink.sv | 124 ++++++++++++
 3 files changed

// File: rtl/flit_sink_pkg.sv
// Shared network constants (constants_2D) and helpers for the flit sink.
// Optional build macro used by flit_sink: SINK_DRAIN_THROTTLE_EN.
`ifndef _INC_CONSTANTS_
`define _INC_CONSTANTS_
`define SIZE       4
`define NUM_NODES  16
`define SINK_CNT_W 8
`endif

package flit_sink_pkg;

    localparam int unsigned FLIT_W = `SIZE;
    localparam int unsigned CNT_W  = `SINK_CNT_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// Flit storage for flit_sink: DEPTH x FLIT_W ring buffer with occupancy tracking.
// Caller guarantees push_i is never asserted when full without a same-edge pop.
module sink_fifo
    import flit_sink_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [FLIT_W-1:0]         wdata_i,
    output logic [FLIT_W-1:0]         rdata_c,
    output logic                      full_c,
    output logic                      empty_c,
    output logic [$clog2(DEPTH):0]    occ_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        // Power-of-two depth lets the pointers wrap naturally.
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_next_c = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end

    assign full_c  = (occ_q == OCC_W'(DEPTH));
    assign empty_c = (occ_q == '0);
    assign rdata_c = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_next_c;
        end
    end

    // Payload storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/flit_sink.sv
// Terminal flit consumer: buffers rx flits, drains them, checks routing and keeps stats.
// Build macro SINK_DRAIN_THROTTLE_EN paces pops with a DRAIN_PERIOD timer; otherwise pop every cycle.
module flit_sink
    import flit_sink_pkg::*;
#(
    parameter int unsigned id             = 0,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned DRAIN_PERIOD   = 4,
    parameter int unsigned expected_flits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [`SIZE-1:0]       data,
    output logic                   busy,
    output logic [`SINK_CNT_W-1:0] rx_count,
    output logic [`SINK_CNT_W-1:0] err_count,
    output logic                   overflow,
    output logic                   done,
    output logic [`SIZE-1:0]       last_data
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("flit_sink: DEPTH must be a power of two >= 2");
    end
    if (DRAIN_PERIOD < 1) begin : g_bad_period
        $error("flit_sink: DRAIN_PERIOD must be >= 1");
    end

    logic              pop_c, push_c, full_c, empty_c;
    logic [FLIT_W-1:0] rdata_c;
    logic [OCC_W-1:0]  occ_next_c;

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [FLIT_W-1:0] last_q, last_d;

    sink_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push_c),
        .pop_i      (pop_c),
        .wdata_i    (data),
        .rdata_c    (rdata_c),
        .full_c     (full_c),
        .empty_c    (empty_c),
        .occ_next_c (occ_next_c)
    );

`ifdef SINK_DRAIN_THROTTLE_EN
    localparam int unsigned       TMR_W      = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(DRAIN_PERIOD - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    assign pop_c = !empty_c && (timer_q == '0);

    // Timer counts down freely and parks at zero until a flit is available.
    always_comb begin
        timer_d = timer_q;
        if (pop_c)                timer_d = TMR_RELOAD;
        else if (timer_q != '0)   timer_d = timer_q - TMR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= TMR_RELOAD;
        else       timer_q <= timer_d;
    end
`else
    assign pop_c = !empty_c;
`endif

    // A same-edge pop frees the slot, so a full FIFO can still accept.
    assign push_c = req && (!full_c || pop_c);

    always_comb begin
        busy_d = (occ_next_c >= OCC_W'(DEPTH - 1));
        rx_d   = rx_q;
        err_d  = err_q;
        ovf_d  = ovf_q;
        done_d = done_q;
        last_d = last_q;
        if (req && !push_c) ovf_d = 1'b1;
        if (push_c) begin
            rx_d = sat_inc(rx_q);
            if (data != FLIT_W'(id)) err_d = sat_inc(err_q);
            if (expected_flits != 0 && 32'(rx_d) == expected_flits) done_d = 1'b1;
        end
        if (pop_c) last_d = rdata_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            rx_q   <= '0;
            err_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            last_q <= '0;
        end else begin
            busy_q <= busy_d;
            rx_q   <= rx_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            last_q <= last_d;
        end
    end

    assign busy      = busy_q;
    assign rx_count  = rx_q;
    assign err_count = err_q;
    assign overflow  = ovf_q;
    assign done      = done_q;
    assign last_data = last_q;

endmodule
